// File: rtl/fifo_rd_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_pkg: shared state type and sizing constants for the read drainer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    SETTLE = 2'd2
  } rd_state_e;

  localparam int BUF_DEPTH = 2;
  localparam int STAT_W    = 16;

endpackage

`default_nettype wire

// File: rtl/fifo_rd_skid.sv
// ----------------------------------------------------------------------------
// fifo_rd_skid: 2-entry in-order output buffer with occupancy and head output. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [Data_Width-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic [Data_Width-1:0] head_o
);

  logic [Data_Width-1:0] mem_q [BUF_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;

  // Push and pop together leave occupancy unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_drainer.sv
// ----------------------------------------------------------------------------
// fifo_rd_drainer: credit-based FIFO read consumer feeding a valid/ready stream.
// Optional FIFO_RD_STATS_EN adds words_read / stall_cycles counters. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_rd_drainer
  import fifo_rd_pkg::*;
#(
  parameter int Data_Width = 8,
  parameter int Buf_Depth  = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_half_full,
  output logic                  fifo_rd_en,
  input  logic [Data_Width-1:0] fifo_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Data_Width-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0]     words_read,
  output logic [STAT_W-1:0]     stall_cycles
`endif
);

  generate
    if (Buf_Depth != BUF_DEPTH) begin : g_bad_depth
      $error("fifo_rd_drainer: Buf_Depth must be 2");
    end
  endgenerate

  rd_state_e  state_q;
  rd_state_e  state_d;
  logic       inflight_q;
  logic [1:0] occ;
  logic       pop_out;
  logic [2:0] credit;

  assign pop_out = m_valid && m_ready;

  // Words already owned (buffered or in flight) after this cycle's output pop.
  assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_out};

  assign fifo_rd_en = (state_q == STREAM) && !fifo_empty && (credit < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty && (fifo_half_full || flush)) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!enable || (fifo_empty && !flush && !fifo_rd_en)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!inflight_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rstn) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
    end
  end

  fifo_rd_skid #(
    .Data_Width (Data_Width)
  ) u_skid (
    .clk_i       (rd_clk),
    .rst_ni      (rd_rstn),
    .push_i      (inflight_q),
    .push_data_i (fifo_data_out),
    .pop_i       (pop_out),
    .occ_o       (occ),
    .head_o      (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign busy    = (state_q != IDLE) || (occ != 2'd0);

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] words_read_q;
  logic [STAT_W-1:0] stall_cycles_q;

  always_ff @(posedge rd_clk) begin
    if (!rd_rstn) begin
      words_read_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (inflight_q) begin
        words_read_q <= words_read_q + 1'b1;
      end
      if (m_valid && !m_ready && (stall_cycles_q != {STAT_W{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
    end
  end

  assign words_read   = words_read_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_drainer.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_drainer: directed bench with a registered-read FIFO model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_drainer;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rd_rstn = 1'b0;
  logic         enable = 1'b0;
  logic         flush = 1'b0;
  logic         m_ready = 1'b0;
  logic         fifo_empty;
  logic         fifo_half_full;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         busy;
  logic [W-1:0] fifo_data_out = '0;
  logic [W-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]  words_read;
  logic [15:0]  stall_cycles;
`endif

  always #5 clk = ~clk;

  fifo_rd_drainer #(
    .Data_Width (W),
    .Buf_Depth  (2)
  ) dut (
    .rd_clk         (clk),
    .rd_rstn        (rd_rstn),
    .enable         (enable),
    .flush          (flush),
    .fifo_empty     (fifo_empty),
    .fifo_half_full (fifo_half_full),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_read     (words_read),
    .stall_cycles   (stall_cycles)
`endif
  );

  // FIFO model: writes from the stimulus, registered read on pop.
  logic [W-1:0] fmem [0:511];
  int wr_idx = 0;
  int rd_idx = 0;
  assign fifo_empty     = (wr_idx == rd_idx);
  assign fifo_half_full = ((wr_idx - rd_idx) >= HALF);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= fmem[rd_idx[8:0]];
      rd_idx        <= rd_idx + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           pops = 0;
  int           viol = 0;
  int           out_cnt = 0;
  int           rise_cyc = -1;
  logic         prev_valid = 1'b0;
  logic [W-1:0] out_data [0:255];
  int           out_cyc [0:255];

  always @(negedge clk) begin
    if (fifo_rd_en) pops++;
    if (fifo_rd_en && fifo_empty) viol++;
    if (m_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = m_valid;
    if (m_valid && m_ready) begin
      out_data[out_cnt[7:0]] = m_data;
      out_cyc[out_cnt[7:0]]  = cyc;
      out_cnt++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx[8:0]] = W'(base + i);
      wr_idx++;
    end
  endtask

  task automatic wait_out(input int target, input int bound);
    for (int i = 0; i < bound && out_cnt < target; i++) tick(1);
  endtask

  initial begin
    int c0, bo, bp, err;

    // Reset, then idle with a non-empty FIFO.
    tick(3);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    rd_rstn = 1'b1;
    load(8'h01, 128);
    tick(6);
    check("idle_pops", pops, 0);
    check("idle_m_valid", m_valid, 0);
    check("idle_busy", busy, 0);

    // Half-full burst at full rate.
    m_ready = 1'b1;
    enable  = 1'b1;
    c0 = cyc;
    bo = out_cnt;
    wait_out(bo + 128, 300);
    check("burst_count", out_cnt - bo, 128);
    check("burst_first_valid_cyc", rise_cyc, c0 + 3);
    check("burst_first_out_cyc", out_cyc[bo], c0 + 3);
    err = 0;
    for (int i = 0; i < 128; i++) begin
      if (out_data[bo + i] !== W'(i + 1)) err++;
      if (out_cyc[bo + i] !== c0 + 3 + i) err++;
    end
    check("burst_order_and_rate", err, 0);
    tick(4);
    check("burst_busy_done", busy, 0);
    check("burst_pops", pops, 128);
`ifdef FIFO_RD_STATS_EN
    check("burst_words_read", words_read, 128);
    check("burst_stall_cycles", stall_cycles, 0);
`endif

    // Backpressure: two pops then hold.
    m_ready = 1'b0;
    bp = pops;
    bo = out_cnt;
    load(8'h30, 20);
    tick(4);
    check("bp_valid", m_valid, 1);
    check("bp_data_early", m_data, 8'h30);
    tick(10);
    check("bp_data_late", m_data, 8'h30);
    check("bp_pops", pops - bp, 2);
    check("bp_no_out", out_cnt - bo, 0);
    m_ready = 1'b1;
    wait_out(bo + 20, 60);
    check("bp_count", out_cnt - bo, 20);
    err = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_data[bo + i] !== W'(8'h30 + i)) err++;
      if (out_cyc[bo + i] !== out_cyc[bo] + i) err++;
    end
    check("bp_order_gapfree", err, 0);
    tick(5);
    check("bp_busy_done", busy, 0);

    // Flush below the half-full threshold.
    flush = 1'b1;
    bo = out_cnt;
    load(8'hA1, 3);
    wait_out(bo + 3, 30);
    check("flush_count", out_cnt - bo, 3);
    err = 0;
    for (int i = 0; i < 3; i++) if (out_data[bo + i] !== W'(8'hA1 + i)) err++;
    check("flush_order", err, 0);
    flush = 1'b0;
    tick(4);
    check("flush_busy_done", busy, 0);
    check("no_pop_when_empty", viol, 0);

    // Drop enable right after the fifth pop.
    bp = pops;
    bo = out_cnt;
    load(8'hC0, 10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (pops - bp >= 5) break;
    end
    enable = 1'b0;
    tick(8);
    check("drop_pops", pops - bp, 5);
    check("drop_count", out_cnt - bo, 5);
    err = 0;
    for (int i = 0; i < 5; i++) if (out_data[bo + i] !== W'(8'hC0 + i)) err++;
    check("drop_order", err, 0);
    check("drop_busy_done", busy, 0);

    // Reset with a full buffer; stream restarts afterwards.
    m_ready = 1'b0;
    enable  = 1'b1;
    bp = pops;
    load(8'hD0, 5);
    tick(8);
    check("prerst_valid", m_valid, 1);
    check("prerst_data", m_data, 8'hC5);
    check("prerst_pops", pops - bp, 2);
    rd_rstn = 1'b0;
    tick(1);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
`ifdef FIFO_RD_STATS_EN
    check("midrst_words_read", words_read, 0);
    check("midrst_stall_cycles", stall_cycles, 0);
`endif
    rd_rstn = 1'b1;
    m_ready = 1'b1;
    bo = out_cnt;
    wait_out(bo + 8, 40);
    check("restart_count", out_cnt - bo, 8);
    check("restart_first", out_data[bo], 8'hC7);
    check("restart_last", out_data[bo + 7], 8'hD4);
`ifdef FIFO_RD_STATS_EN
    check("restart_words_read", words_read, 8);
`endif
    enable = 1'b0;
    tick(5);
    check("final_busy", busy, 0);
    check("final_no_pop_when_empty", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_drainer.md
# fifo_rd_drainer

Read-side consumer for the asynchronous FIFO, in the `rd_clk` domain. It decides when to pop the FIFO, captures the registered read data and presents it downstream on a valid/ready stream. A 2-entry output buffer with credit-based read issue means the FIFO is never over-read and downstream backpressure never drops a word. It is the counterpart of the write-side stimulus and pairs with the existing FIFO interface and its empty/full assertions.

## Interface
- `Data_Width`, default 8: FIFO/stream data width.
- `Buf_Depth`, default 2: output buffer entries; fixed at 2, any other value is a compile-time error.
- `rd_clk` in 1: read-domain clock; sole clock.
- `rd_rstn` in 1: synchronous, active-low reset.
- `enable` in 1: drainer allowed to start a new stream.
- `flush` in 1: drain even when FIFO below half-full.
- `fifo_empty` in 1: FIFO empty flag, `rd_clk` domain.
- `fifo_half_full` in 1: FIFO at or above half occupancy.
- `fifo_rd_en` out 1: FIFO pop request.
- `fifo_data_out` in `Data_Width`: FIFO read data, valid the cycle after an accepted pop.
- `m_valid` out 1: stream word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out `Data_Width`: stream word.
- `busy` out 1: state is not IDLE, or the buffer is non-empty.

## Operation
- States:
  - IDLE: no pops.
  - STREAM: pops permitted.
  - SETTLE: no new pops; waits for the in-flight word to land.
- IDLE→STREAM when `enable && !fifo_empty && (fifo_half_full || flush)`.
- STREAM→SETTLE when `!enable`, or when `fifo_empty && !flush` in a cycle with no pop issued.
- SETTLE→IDLE when `inflight==0`.
- Pop rule: `fifo_rd_en = (state==STREAM) && !fifo_empty && (occ + inflight - pop_out) < 2`.
  - `occ` is buffer occupancy (0..2), `inflight` is 0..1, `pop_out = m_valid && m_ready`.
  - `fifo_rd_en` is never high while `fifo_empty` is high.
- Capture: when `inflight==1`, `fifo_data_out` is written into the buffer tail at that clock edge. `inflight` follows `fifo_rd_en` with one cycle of delay.
- Output ordering:
  - `m_data` is the buffer head and `m_valid = (occ!=0)`.
  - Words leave in FIFO order.
  - `m_data` is held stable while `m_valid && !m_ready`.
- Simultaneous capture and pop: `occ` is unchanged; the head advances and the new word goes to the tail.
- Buffer pointers are 1 bit wide and wrap modulo 2. `occ` is 2 bits and saturates by construction; overflow is impossible by the credit rule.
- Deasserting `enable` mid-stream: no further pops; the in-flight word is still captured; buffered words are still delivered.
- `busy` falls only when IDLE and `occ==0`.

## Timing
- Reset: synchronous; while `rd_rstn==0` at an edge:
  - state → IDLE.
  - `occ`, `inflight` and pointers → 0.
  - `fifo_rd_en`, `m_valid` and `busy` → 0.
  - `m_data` → 0.
  - Reset overrides all events.
- Reset mid-stream discards buffered and in-flight words. A FIFO word popped in the cycle before reset is lost by design.
- `fifo_rd_en` is combinational from registered state and `fifo_empty`.
- Latency:
  - Trigger sampled at edge N → STREAM in cycle N+1 → first `fifo_rd_en` in N+1 → captured at end of N+2 → `m_valid` high in N+3.
- Throughput: with `m_ready` held high and the FIFO non-empty, one word per cycle sustained.
- Backpressure: with `m_ready` low, at most 2 pops occur before `fifo_rd_en` stops.

## Configuration
- Macro `FIFO_RD_STATS_EN`.
- Defined: adds output `words_read` [15:0], which increments on each captured word, wraps 0xFFFF→0, and resets to 0. Also adds output `stall_cycles` [15:0], which increments on `m_valid && !m_ready`, saturates at 0xFFFF, and resets to 0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

## Structure
- Shared package `fifo_rd_pkg`:
  - State enum `rd_state_e` {IDLE, STREAM, SETTLE}.
  - `BUF_DEPTH=2`.
  - Counter width constant `STAT_W=16`.
- One sub-module, `fifo_rd_skid`: the 2-entry buffer with occupancy, push/pop and head output. The top level holds the FSM, the credit logic and the stats counters.

## Test plan
- Reset then idle: FIFO non-empty, `enable=0` → `fifo_rd_en`, `m_valid` and `busy` all remain 0.
- Half-full burst: preload 0x01..0x80 (128 words), `enable=1`, `m_ready=1` → `m_data` 0x01..0x80 in order, 1 word/cycle, first `m_valid` 3 cycles after trigger.
- Backpressure: stream active, `m_ready=0` for 10 cycles → exactly 2 pops, `m_data` stable, no loss; on `m_ready=1`, the sequence resumes gap-free.
- Flush below threshold: 3 words (0xA1, 0xA2, 0xA3), `flush=1` → all 3 delivered, then SETTLE→IDLE and `busy=0`, with `fifo_rd_en` never high while `fifo_empty` is high.
- Mid-stream `enable` drop: drop after the 5th pop → in-flight word still delivered, exactly 5 words out, state returns to IDLE.
- Reset mid-stream with `FIFO_RD_STATS_EN`: `rd_rstn=0` for 1 cycle with `occ=2` → `m_valid=0` next cycle, `words_read=0`; the stream restarts on the next trigger.
